// File: rtl/psram_qpi_slave.sv
// psram_qpi_slave: QPI PSRAM responder, the device side of the PSRAM link.
// Everything runs on clk_i. SCK, CE# and IO are brought in through 2-flop
// synchronizers, and SCK edges are found from the synchronized value.
// The block decodes quad read (EB), quad write (38) and read ID (9F), and
// serves them from an internal byte array.
//
// Ports:
//   clk_i          system clock (>= 4x SCK)
//   rst_n_i        asynchronous active-low reset
//   psram_sck_i    serial clock from the controller
//   psram_ce_i     chip enable, active-low
//   psram_io_in_i  IO[3:0] as driven by the controller
//   psram_io_out_o IO[3:0] driven by this block
//   psram_io_en_o  per-line output enable, 1 = drive
module psram_qpi_slave #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned READ_WAIT = 6,
    parameter logic [7:0]  MFID      = 8'h0D,
    parameter logic [7:0]  KGD       = 8'h5D
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [3:0] psram_io_in_i,
    output logic [3:0] psram_io_out_o,
    output logic [3:0] psram_io_en_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    // Synchronizers
    logic [1:0] sck_sync_q, ce_sync_q;
    logic [3:0] io_s1_q, io_s2_q;
    logic       sck_prev_q, ce_prev_q;

    // CE# stages reset to 0 (asserted) so that a CE# already low at reset
    // release yields no falling edge; a fresh high-then-low is required.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_sync_q <= '0;
            ce_sync_q  <= '0;
            io_s1_q    <= '0;
            io_s2_q    <= '0;
            sck_prev_q <= 1'b0;
            ce_prev_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], psram_sck_i};
            ce_sync_q  <= {ce_sync_q[0], psram_ce_i};
            io_s1_q    <= psram_io_in_i;
            io_s2_q    <= io_s1_q;
            sck_prev_q <= sck_sync_q[1];
            ce_prev_q  <= ce_sync_q[1];
        end
    end

    logic sck_rise, sck_fall, ce_fall, ce_high;
    assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
    assign ce_fall  = ~ce_sync_q[1] & ce_prev_q;
    assign ce_high  = ce_sync_q[1];

    // Control state
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    nib_q, nib_d;     // held first nibble (command or write byte)
    logic          hi_q, hi_d;       // next data nibble is the high one
    logic          wr_cmd_q, wr_cmd_d;
    logic          id_q, id_d;
    logic [3:0]    out_q, out_d;
    logic [3:0]    en_q, en_d;

    logic [7:0]    mem_q [DEPTH];
    logic          wr_en;
    logic [7:0]    rd_byte;

    // Read ID alternates MFID/KGD; the address starts at 0 for 9F so its LSB
    // selects the byte.
    assign rd_byte = id_q ? (addr_q[0] ? KGD : MFID) : mem_q[addr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            nib_q    <= '0;
            hi_q     <= 1'b1;
            wr_cmd_q <= 1'b0;
            id_q     <= 1'b0;
            out_q    <= '0;
            en_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            nib_q    <= nib_d;
            hi_q     <= hi_d;
            wr_cmd_q <= wr_cmd_d;
            id_q     <= id_d;
            out_q    <= out_d;
            en_q     <= en_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        nib_d    = nib_q;
        hi_d     = hi_q;
        wr_cmd_d = wr_cmd_q;
        id_d     = id_q;
        out_d    = out_q;
        en_d     = en_q;
        wr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                hi_d  = 1'b1;
                en_d  = '0;
                if (ce_fall) state_d = S_CMD;
            end
            S_CMD: if (sck_rise) begin
                if (cnt_q == '0) begin
                    nib_d = io_s2_q;
                    cnt_d = CW'(1);
                end else begin
                    cnt_d  = '0;
                    addr_d = '0;
                    hi_d   = 1'b1;
                    case ({nib_q, io_s2_q})
                        8'hEB: begin wr_cmd_d = 1'b0; id_d = 1'b0; state_d = S_ADDR; end
                        8'h38: begin wr_cmd_d = 1'b1; id_d = 1'b0; state_d = S_ADDR; end
                        // Read ID has no dummy cycles: straight to data.
                        8'h9F: begin wr_cmd_d = 1'b0; id_d = 1'b1; state_d = S_RDATA; end
                        default: state_d = S_IGNORE;
                    endcase
                end
            end
            S_ADDR: if (sck_rise) begin
                // Only the low AW bits survive the shift, which is the alias.
                addr_d = (addr_q << 4) | AW'(io_s2_q);
                if (cnt_q == CW'(5)) begin
                    cnt_d = '0;
                    if (wr_cmd_q)            state_d = S_WDATA;
                    else if (READ_WAIT == 0) state_d = S_RDATA;
                    else                     state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: if (sck_rise) begin
                if (32'(cnt_q) == READ_WAIT - 1) begin
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RDATA: if (sck_fall) begin
                en_d = 4'hF;
                if (hi_q) begin
                    out_d = rd_byte[7:4];
                    hi_d  = 1'b0;
                end else begin
                    out_d  = rd_byte[3:0];
                    hi_d   = 1'b1;
                    addr_d = addr_q + AW'(1);
                end
            end
            S_WDATA: if (sck_rise) begin
                if (hi_q) begin
                    nib_d = io_s2_q;
                    hi_d  = 1'b0;
                end else begin
                    wr_en  = 1'b1;
                    hi_d   = 1'b1;
                    addr_d = addr_q + AW'(1);
                end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
        endcase

        // CE# high aborts anything in flight.
        if (ce_high) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = 1'b1;
            en_d    = '0;
            out_d   = '0;
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[addr_q] <= {nib_q, io_s2_q};
    end

    assign psram_io_out_o = out_q;
    assign psram_io_en_o  = en_q;
endmodule

// File: tb/tb_psram_qpi_slave.sv
module tb_psram_qpi_slave;
  localparam int DEPTH = 1024;
  localparam int RW    = 6;
  localparam int HALF  = 50;
  localparam logic [7:0] MFID = 8'h0D;
  localparam logic [7:0] KGD  = 8'h5D;

  logic clk = 1'b0;
  logic rst_n, sck, ce;
  logic [3:0] io_in, io_out, io_en;

  always #5 clk = ~clk;

  psram_qpi_slave #(.DEPTH(DEPTH), .READ_WAIT(RW), .MFID(MFID), .KGD(KGD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .psram_sck_i(sck), .psram_ce_i(ce),
    .psram_io_in_i(io_in), .psram_io_out_o(io_out), .psram_io_en_o(io_en)
  );

  int n_pass = 0, n_chk = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  int en_bad;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nb;
    logic [31:0] data;   // bytes MSB first: write data or expected read data
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] got, output logic [3:0] en);
    io_in = nib; #HALF;
    got = io_out; en = io_en;
    sck = 1'b1; #HALF;
    sck = 1'b0;
  endtask

  // One CE#-framed transaction. Write data comes from wq, read bytes land in rq.
  task automatic xact(input logic [7:0] cmd, input logic [23:0] addr, input int naddr,
                      input int nwait, input int nwnib, input int nrnib);
    logic [3:0] g, e;
    logic [7:0] b;
    rq.delete(); en_bad = 0; b = 8'h00;
    ce = 1'b0; #HALF;
    sck_cycle(cmd[7:4], g, e); if (e !== 4'h0) en_bad++;
    sck_cycle(cmd[3:0], g, e); if (e !== 4'h0) en_bad++;
    for (int i = 0; i < naddr; i++) begin
      sck_cycle(addr[23-4*i -: 4], g, e); if (e !== 4'h0) en_bad++;
    end
    for (int i = 0; i < nwait; i++) begin
      sck_cycle(4'($urandom_range(15)), g, e); if (e !== 4'h0) en_bad++;
    end
    for (int i = 0; i < nwnib; i++) begin
      b = wq[i/2];
      sck_cycle((i % 2 == 0) ? b[7:4] : b[3:0], g, e); if (e !== 4'h0) en_bad++;
    end
    for (int i = 0; i < nrnib; i++) begin
      sck_cycle(4'h0, g, e); if (e !== 4'hF) en_bad++;
      if (i % 2 == 0) b[7:4] = g;
      else begin b[3:0] = g; rq.push_back(b); end
    end
    #HALF; ce = 1'b1;
    #30; if (io_en !== 4'h0) en_bad++;
    #(2*HALF);
  endtask

  task automatic do_write(input logic [23:0] addr, input int nnib);
    xact(8'h38, addr, 6, 0, nnib, 0);
    for (int k = 0; k < nnib/2; k++) model[(int'(addr) + k) % DEPTH] = wq[k];
  endtask

  task automatic do_read(input logic [23:0] addr, input int n);
    xact(8'hEB, addr, 6, RW, 0, 2*n);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0] ex;
    logic [23:0] a;
    logic [3:0] g, e;
    int n, kind;

    rst_n = 1'b0; sck = 1'b0; ce = 1'b1; io_in = 4'h0;
    #23;
    chk("reset io_out", 32'(io_out), 32'h0);
    chk("reset io_en", 32'(io_en), 32'h0);
    #7; rst_n = 1'b1; #100;

    // Fill the whole array so every later read has a known expectation.
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(8'($urandom));
    do_write(24'h0, 2*DEPTH);
    chk("fill en", en_bad, 0);

    vt[0] = '{8'h38, 24'h000010, 4, 32'hA53C7E81};
    vt[1] = '{8'hEB, 24'h000010, 4, 32'hA53C7E81};
    vt[2] = '{8'h9F, 24'h000000, 4, 32'h0D5D0D5D};
    vt[3] = '{8'h38, 24'h0003FF, 2, 32'h11220000};
    vt[4] = '{8'hEB, 24'h000000, 1, 32'h22000000};
    vt[5] = '{8'hEB, 24'h0003FF, 2, 32'h11220000};
    vt[6] = '{8'hEB, 24'h400010, 4, 32'hA53C7E81};
    for (int i = 0; i < 7; i++) begin
      d = vt[i].data;
      if (vt[i].cmd == 8'h38) begin
        wq.delete();
        for (int k = 0; k < vt[i].nb; k++) wq.push_back(d[31-8*k -: 8]);
        do_write(vt[i].addr, 2*vt[i].nb);
      end else if (vt[i].cmd == 8'h9F) begin
        xact(8'h9F, 24'h0, 0, 0, 0, 2*vt[i].nb);
      end else begin
        do_read(vt[i].addr, vt[i].nb);
      end
      chk($sformatf("vec%0d en", i), en_bad, 0);
      if (vt[i].cmd != 8'h38) begin
        chk($sformatf("vec%0d count", i), rq.size(), vt[i].nb);
        for (int k = 0; k < vt[i].nb && k < rq.size(); k++)
          chk($sformatf("vec%0d byte%0d", i, k), 32'(rq[k]), 32'(d[31-8*k -: 8]));
      end
    end

    // Unknown command: never drives, then a read still works.
    xact(8'h05, 24'h0, 0, 10, 0, 0);
    chk("unknown cmd en", en_bad, 0);
    do_read(24'h10, 4);
    chk("after unknown b0", 32'(rq[0]), 32'hA5);
    chk("after unknown b3", 32'(rq[3]), 32'h81);

    // Trailing half byte is dropped.
    wq.delete(); wq.push_back(8'hC3);
    do_write(24'h21, 2);
    wq.delete(); wq.push_back(8'h5A); wq.push_back(8'hF0);
    do_write(24'h20, 3);
    do_read(24'h20, 2);
    chk("partial b0", 32'(rq[0]), 32'h5A);
    chk("partial b1", 32'(rq[1]), 32'hC3);

    // Reset pulse in the middle of a read, CE# still low at release.
    en_bad = 0;
    ce = 1'b0; #HALF;
    d = 32'hEB000010;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(d[31-4*i -: 4], g, e); if (e !== 4'h0) en_bad++;
    end
    for (int i = 0; i < RW; i++) begin
      sck_cycle(4'h0, g, e); if (e !== 4'h0) en_bad++;
    end
    for (int i = 0; i < 3; i++) sck_cycle(4'h0, g, e);
    chk("rst-seq pre en", en_bad, 0);
    chk("rst-seq nibble2", 32'(g), 32'h3);
    #30;
    chk("rst-seq driving", 32'(io_en), 32'hF);
    rst_n = 1'b0; #1;
    chk("rst-seq en", 32'(io_en), 32'h0);
    chk("rst-seq out", 32'(io_out), 32'h0);
    #20; rst_n = 1'b1;
    en_bad = 0;
    d = 32'hEB000010;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(d[31-4*i -: 4], g, e); if (e !== 4'h0) en_bad++;
    end
    for (int i = 0; i < RW + 2; i++) begin
      sck_cycle(4'h0, g, e); if (e !== 4'h0) en_bad++;
    end
    chk("rst-seq held off", en_bad, 0);
    #HALF; ce = 1'b1; #100;
    do_read(24'h10, 2);
    chk("post-rst b0", 32'(rq[0]), 32'hA5);
    chk("post-rst b1", 32'(rq[1]), 32'h3C);

    // Randomized transactions against the byte-array model.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 6);
      a = 24'($urandom);
      if (kind == 0) begin
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        do_write(a, 2*n);
        chk($sformatf("rnd%0d wr en", t), en_bad, 0);
      end else begin
        if (kind == 1) do_read(a, n);
        else xact(8'h9F, 24'h0, 0, 0, 0, 2*n);
        chk($sformatf("rnd%0d en", t), en_bad, 0);
        chk($sformatf("rnd%0d count", t), rq.size(), n);
        for (int k = 0; k < n && k < rq.size(); k++) begin
          if (kind == 1) ex = model[(int'(a) + k) % DEPTH];
          else ex = (k % 2 == 0) ? MFID : KGD;
          chk($sformatf("rnd%0d byte%0d", t, k), 32'(rq[k]), 32'(ex));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
